// File: rtl/vram_arbiter.sv
// Shared text/font VRAM arbiter: video fetch slots always win, CPU accesses fill the idle slots.
// Define VRAM_CPU_FONT_WR_EN to let CPU writes reach the font region (0x1000-0x1FFF).
module vram_arbiter (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        fetch_cell,
  input  logic        fetch_font,
  input  logic [11:0] cell_addr,
  input  logic [3:0]  font_line,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code,
  output logic [7:0]  glyph_bits,
  output logic        glyph_valid
);

  localparam int unsigned ADDR_W = 13;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DATA = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CELL = 2'd1;
  localparam logic [1:0] TAG_FONT = 2'd2;
  localparam logic [1:0] TAG_CPU  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              holdoff_q, holdoff_d;
  logic [1:0]        tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] font_addr;
  logic              issue_cell, issue_font, issue_cpu;
  logic              cpu_wr_allowed;

  assign font_addr = {1'b1, char_code, font_line};

`ifdef VRAM_CPU_FONT_WR_EN
  assign cpu_wr_allowed = 1'b1;
`else
  assign cpu_wr_allowed = ~cpu_addr[ADDR_W-1];
`endif

  // Slot owner for this cycle; nothing issues while reset is asserted.
  always_comb begin
    issue_cell = 1'b0;
    issue_font = 1'b0;
    issue_cpu  = 1'b0;
    if (rst_n) begin
      issue_cell = fetch_cell;
      issue_font = fetch_font & ~fetch_cell;
      issue_cpu  = cpu_req & ~fetch_cell & ~fetch_font &
                   (state_q == ST_IDLE) & ~holdoff_q;
    end
  end

  // RAM port drive; the address holds its last issued value on idle cycles.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    tag_d     = TAG_NONE;
    if (issue_cell) begin
      ram_addr = {1'b0, cell_addr};
      tag_d    = TAG_CELL;
    end else if (issue_font) begin
      ram_addr = font_addr;
      tag_d    = TAG_FONT;
    end else if (issue_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we & cpu_wr_allowed;
      tag_d    = TAG_CPU;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  // CPU FSM; the cycle after DONE still ignores a held request.
  always_comb begin
    state_d   = state_q;
    holdoff_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_cpu) begin
          state_d = cpu_we ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        holdoff_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      holdoff_q <= 1'b0;
      tag_q     <= TAG_NONE;
      addr_q    <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      tag_q     <= tag_d;
      cpu_ack   <= (state_d == ST_DONE);
      if (issue_cell | issue_font | issue_cpu) begin
        addr_q <= ram_addr;
      end
      if ((state_q == ST_WAIT_DATA) && (tag_q == TAG_CPU)) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

  // Video return path, routed by the tag of the access issued last cycle.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      char_code   <= '0;
      glyph_bits  <= '0;
      glyph_valid <= 1'b0;
    end else begin
      glyph_valid <= (tag_q == TAG_FONT);
      if (tag_q == TAG_CELL) begin
        char_code <= ram_rdata;
      end
      if (tag_q == TAG_FONT) begin
        glyph_bits <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized video line against a slot-level model.
`timescale 1ns/1ps
module tb_vram_arbiter;

`ifdef VRAM_CPU_FONT_WR_EN
  localparam bit FONT_WR = 1'b1;
`else
  localparam bit FONT_WR = 1'b0;
`endif

  logic        clk_vga;
  logic        rst_n;
  logic        fetch_cell;
  logic        fetch_font;
  logic [11:0] cell_addr;
  logic [3:0]  font_line;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic [7:0]  glyph_bits;
  logic        glyph_valid;

  logic [7:0] dev_mem [0:8191];
  logic [7:0] ref_mem [0:8191];
  int n_cmp;
  int n_bad;

  vram_arbiter dut (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .fetch_cell (fetch_cell),
    .fetch_font (fetch_font),
    .cell_addr  (cell_addr),
    .font_line  (font_line),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .char_code  (char_code),
    .glyph_bits (glyph_bits),
    .glyph_valid(glyph_valid)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // Synchronous RAM with registered read data
  always @(posedge clk_vga) begin
    if (ram_we) dev_mem[ram_addr] <= ram_wdata;
    ram_rdata <= dev_mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    fetch_cell = 1'b0;
    fetch_font = 1'b0;
    cell_addr  = '0;
    font_line  = '0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_vga);
    #2;
    n_cmp++; if ({cpu_ack, glyph_valid, ram_we} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {cpu_ack, glyph_valid, ram_we}); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
    n_cmp++; if (char_code !== 8'h00) begin n_bad++; $display("FAIL reset_char_code got=%h exp=00", char_code); end
    n_cmp++; if (glyph_bits !== 8'h00) begin n_bad++; $display("FAIL reset_glyph_bits got=%h exp=00", glyph_bits); end
    n_cmp++; if (ram_addr !== 13'h0000) begin n_bad++; $display("FAIL reset_ram_addr got=%h exp=0000", ram_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_write();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h41;
    settle();
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_ram_we got=%b exp=1", ram_we); end
    n_cmp++; if (ram_addr !== 13'h0123) begin n_bad++; $display("FAIL wr_ram_addr got=%h exp=0123", ram_addr); end
    n_cmp++; if (ram_wdata !== 8'h41) begin n_bad++; $display("FAIL wr_ram_wdata got=%h exp=41", ram_wdata); end
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL wr_early_ack got=%b exp=0", cpu_ack); end
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack got=%b exp=1", cpu_ack); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_width got=%b exp=0", cpu_ack); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL wr_idle_we got=%b exp=0", ram_we); end
    n_cmp++; if (ram_addr !== 13'h0123) begin n_bad++; $display("FAIL wr_addr_hold got=%h exp=0123", ram_addr); end
    n_cmp++; if (dev_mem[13'h0123] !== 8'h41) begin n_bad++; $display("FAIL wr_mem got=%h exp=41", dev_mem[13'h0123]); end
  endtask

  task automatic test_read_collision();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    fetch_cell = 1'b1; cell_addr = 12'h005;
    settle();
    n_cmp++; if (ram_addr !== 13'h0005) begin n_bad++; $display("FAIL coll_video_addr got=%h exp=0005", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL coll_video_we got=%b exp=0", ram_we); end
    next_cycle(); fetch_cell = 1'b0; settle();
    n_cmp++; if (ram_addr !== 13'h0123) begin n_bad++; $display("FAIL coll_cpu_addr got=%h exp=0123", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL coll_cpu_we got=%b exp=0", ram_we); end
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL coll_early_ack got=%b exp=0", cpu_ack); end
    n_cmp++; if (char_code !== 8'h41) begin n_bad++; $display("FAIL coll_char_code got=%h exp=41", char_code); end
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL coll_ack got=%b exp=1", cpu_ack); end
    n_cmp++; if (cpu_rdata !== 8'h41) begin n_bad++; $display("FAIL coll_rdata got=%h exp=41", cpu_rdata); end
    cpu_req = 1'b0;
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL coll_ack_width got=%b exp=0", cpu_ack); end
    n_cmp++; if (cpu_rdata !== 8'h41) begin n_bad++; $display("FAIL coll_rdata_hold got=%h exp=41", cpu_rdata); end
  endtask

  task automatic test_font_fetch();
    next_cycle();
    fetch_cell = 1'b1; cell_addr = 12'h005;
    next_cycle(); fetch_cell = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    fetch_font = 1'b1; font_line = 4'd3;
    settle();
    n_cmp++; if (ram_addr !== 13'h1413) begin n_bad++; $display("FAIL font_addr got=%h exp=1413", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL font_we got=%b exp=0", ram_we); end
    next_cycle(); fetch_font = 1'b0; settle();
    n_cmp++; if (glyph_valid !== 1'b0) begin n_bad++; $display("FAIL font_valid_early got=%b exp=0", glyph_valid); end
    next_cycle(); settle();
    n_cmp++; if (glyph_valid !== 1'b1) begin n_bad++; $display("FAIL font_valid got=%b exp=1", glyph_valid); end
    n_cmp++; if (glyph_bits !== 8'hA5) begin n_bad++; $display("FAIL font_bits got=%h exp=a5", glyph_bits); end
    next_cycle(); settle();
    n_cmp++; if (glyph_valid !== 1'b0) begin n_bad++; $display("FAIL font_valid_width got=%b exp=0", glyph_valid); end
    // both strobes together: cell wins, font dropped
    next_cycle();
    fetch_cell = 1'b1; fetch_font = 1'b1; cell_addr = 12'h007; font_line = 4'd9;
    settle();
    n_cmp++; if (ram_addr !== 13'h0007) begin n_bad++; $display("FAIL both_addr got=%h exp=0007", ram_addr); end
    next_cycle(); fetch_cell = 1'b0; fetch_font = 1'b0;
    next_cycle(); settle();
    n_cmp++; if (glyph_valid !== 1'b0) begin n_bad++; $display("FAIL both_font_dropped got=%b exp=0", glyph_valid); end
    n_cmp++; if (char_code !== 8'h3C) begin n_bad++; $display("FAIL both_char_code got=%h exp=3c", char_code); end
  endtask

  task automatic test_font_write();
    logic [7:0] exp_val;
    exp_val = FONT_WR ? 8'hE1 : 8'h77;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1010; cpu_wdata = 8'hE1;
    settle();
    n_cmp++; if (ram_addr !== 13'h1010) begin n_bad++; $display("FAIL fwr_addr got=%h exp=1010", ram_addr); end
    n_cmp++; if (ram_we !== FONT_WR) begin n_bad++; $display("FAIL fwr_we got=%b exp=%b", ram_we, FONT_WR); end
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL fwr_ack got=%b exp=1", cpu_ack); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    next_cycle(); settle();
    n_cmp++; if (dev_mem[13'h1010] !== exp_val) begin n_bad++; $display("FAIL fwr_mem got=%h exp=%h", dev_mem[13'h1010], exp_val); end
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1010;
    settle();
    n_cmp++; if (ram_addr !== 13'h1010) begin n_bad++; $display("FAIL frd_addr got=%h exp=1010", ram_addr); end
    next_cycle(); settle();
    next_cycle(); settle();
    n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL frd_ack got=%b exp=1", cpu_ack); end
    n_cmp++; if (cpu_rdata !== exp_val) begin n_bad++; $display("FAIL frd_rdata got=%h exp=%h", cpu_rdata, exp_val); end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    settle();
    n_cmp++; if (ram_addr !== 13'h0123) begin n_bad++; $display("FAIL rst_issue_addr got=%h exp=0123", ram_addr); end
    next_cycle();
    rst_n = 1'b0; cpu_req = 1'b0;
    settle();
    n_cmp++; if ({cpu_ack, glyph_valid, ram_we} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_flags got=%b exp=000", {cpu_ack, glyph_valid, ram_we}); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_mid_rdata got=%h exp=00", cpu_rdata); end
    n_cmp++; if (char_code !== 8'h00) begin n_bad++; $display("FAIL rst_mid_char got=%h exp=00", char_code); end
    n_cmp++; if (glyph_bits !== 8'h00) begin n_bad++; $display("FAIL rst_mid_glyph got=%h exp=00", glyph_bits); end
    n_cmp++; if (ram_addr !== 13'h0000) begin n_bad++; $display("FAIL rst_mid_addr got=%h exp=0000", ram_addr); end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle(); settle();
      n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_no_ack cycle=%0d got=%b exp=0", i, cpu_ack); end
    end
  endtask

  task automatic test_random_line();
    logic [7:0]  hist;
    logic [12:0] last_addr, exp_addr;
    logic [7:0]  vis_char, vis_glyph, vis_rdata, char_val, glyph_val, rd_val;
    int          char_due, glyph_due, ack_due, last_ack, attempt, gap, bad_words;
    logic        issued, rd_txn, exp_we, exp_gv, is_cell, is_font, is_cpu, drop_next;

    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8192; i++) ref_mem[i] = dev_mem[i];
    hist = '0; last_addr = '0;
    vis_char = '0; vis_glyph = '0; vis_rdata = '0;
    char_val = '0; glyph_val = '0; rd_val = '0;
    char_due = -100; glyph_due = -100; ack_due = -100; last_ack = -10;
    attempt = 0; gap = 0; issued = 1'b0; rd_txn = 1'b0; drop_next = 1'b0;

    for (int cyc = 0; cyc < 720; cyc++) begin
      next_cycle();
      if (char_due == cyc) vis_char = char_val;
      exp_gv = (glyph_due == cyc);
      if (exp_gv) vis_glyph = glyph_val;
      if (ack_due == cyc && rd_txn) vis_rdata = rd_val;

      // video strobes: never adjacent, at most two in any eight cycles
      fetch_cell = 1'b0; fetch_font = 1'b0;
      if (!hist[0] && $countones(hist[6:0]) < 2 && $urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 9))
          0: begin fetch_cell = 1'b1; fetch_font = 1'b1; end
          1, 2, 3, 4: fetch_cell = 1'b1;
          default: fetch_font = 1'b1;
        endcase
        cell_addr = 12'($urandom);
        font_line = 4'($urandom);
      end

      if (drop_next) begin
        cpu_req = 1'b0; drop_next = 1'b0;
        gap = $urandom_range(0, 2);
      end
      if (!cpu_req) begin
        if (gap == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom);
          cpu_addr  = {1'($urandom), 6'd0, 6'($urandom)};
          cpu_wdata = 8'($urandom);
          issued    = 1'b0;
          attempt   = (cyc > last_ack + 2) ? cyc : last_ack + 2;
        end else begin
          gap--;
        end
      end
      settle();

      is_cell = fetch_cell;
      is_font = fetch_font && !fetch_cell;
      is_cpu  = cpu_req && !issued && !(fetch_cell || fetch_font) && (cyc >= last_ack + 2);
      exp_addr = last_addr;
      exp_we   = 1'b0;
      if (is_cell) exp_addr = {1'b0, cell_addr};
      else if (is_font) exp_addr = {1'b1, vis_char, font_line};
      else if (is_cpu) begin
        exp_addr = cpu_addr;
        exp_we   = cpu_we && (FONT_WR || !cpu_addr[12]);
      end

      n_cmp++; if (ram_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, exp_addr); end
      n_cmp++; if (ram_we !== exp_we) begin n_bad++; $display("FAIL rnd_ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, exp_we); end
      if (is_cpu && cpu_we) begin
        n_cmp++; if (ram_wdata !== cpu_wdata) begin n_bad++; $display("FAIL rnd_ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, cpu_wdata); end
      end
      n_cmp++; if (cpu_ack !== (ack_due == cyc)) begin n_bad++; $display("FAIL rnd_cpu_ack cyc=%0d got=%b exp=%b", cyc, cpu_ack, (ack_due == cyc)); end
      n_cmp++; if (cpu_rdata !== vis_rdata) begin n_bad++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, vis_rdata); end
      n_cmp++; if (glyph_valid !== exp_gv) begin n_bad++; $display("FAIL rnd_glyph_valid cyc=%0d got=%b exp=%b", cyc, glyph_valid, exp_gv); end
      n_cmp++; if (glyph_bits !== vis_glyph) begin n_bad++; $display("FAIL rnd_glyph_bits cyc=%0d got=%h exp=%h", cyc, glyph_bits, vis_glyph); end
      n_cmp++; if (char_code !== vis_char) begin n_bad++; $display("FAIL rnd_char_code cyc=%0d got=%h exp=%h", cyc, char_code, vis_char); end
      if (cpu_ack === 1'b1 && cpu_req) begin
        n_cmp++; if (cyc - attempt > 4) begin n_bad++; $display("FAIL rnd_ack_latency cyc=%0d got=%0d exp<=4", cyc, cyc - attempt); end
      end

      if (is_cell) begin char_due = cyc + 2; char_val = ref_mem[exp_addr]; end
      if (is_font) begin glyph_due = cyc + 2; glyph_val = ref_mem[exp_addr]; end
      if (is_cpu) begin
        issued = 1'b1;
        if (cpu_we) begin
          if (exp_we) ref_mem[exp_addr] = cpu_wdata;
          ack_due = cyc + 1; rd_txn = 1'b0;
        end else begin
          rd_val = ref_mem[exp_addr];
          ack_due = cyc + 2; rd_txn = 1'b1;
        end
      end
      if (is_cell || is_font || is_cpu) last_addr = exp_addr;
      hist = {hist[6:0], fetch_cell | fetch_font};

      if (ack_due == cyc) begin
        last_ack = cyc; drop_next = 1'b1;
      end else if (cpu_req && !drop_next && cyc > attempt + 6) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_cpu_timeout cyc=%0d got=no_ack exp=ack_within_4", cyc);
        last_ack = cyc; drop_next = 1'b1; ack_due = -100;
      end
    end

    clear_inputs();
    repeat (4) next_cycle();
    bad_words = 0;
    for (int i = 0; i < 8192; i++) if (dev_mem[i] !== ref_mem[i]) bad_words++;
    n_cmp++; if (bad_words != 0) begin n_bad++; $display("FAIL rnd_ram_contents got=%0d_differing_bytes exp=0", bad_words); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 8192; i++) dev_mem[i] = 8'($urandom);
    dev_mem[13'h0005] = 8'h41;
    dev_mem[13'h0007] = 8'h3C;
    dev_mem[13'h1413] = 8'hA5;
    dev_mem[13'h1010] = 8'h77;
    test_reset();
    test_cpu_write();
    test_read_collision();
    test_font_fetch();
    test_font_write();
    test_reset_mid_read();
    test_random_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
